// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx channel among NUM_REQ byte producers.
// Optional send timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 req_err,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_req,
    output logic [7:0]           tx_data,
    input  logic                 tx_ack
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [IW-1:0]        gidx, gidx_n;
    logic [IW-1:0]        owner, owner_n;
    logic                 lock, lock_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic                 tx_req_n;
    logic [7:0]           tx_data_n;
    logic [NUM_REQ-1:0]   req_ack_n;

    logic                 lock_hold;
    logic [NUM_REQ-1:0]   cand;
    logic [IW-1:0]        win;
    logic                 found;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt, cnt_n;
    logic        req_err_n;
`endif

    // Pick the next winner: locked owner only, else first set bit after ptr.
    always_comb begin
        int idx;
        idx       = 0;
        lock_hold = lock && req[owner];
        cand      = lock_hold ? (req & (ONE << owner)) : req;
        found     = 1'b0;
        win       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic of the IDLE/SEND/DONE sequence.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gidx_n    = gidx;
        owner_n   = owner;
        lock_n    = lock;
        grant_n   = grant;
        tx_req_n  = tx_req;
        tx_data_n = tx_data;
        req_ack_n = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_n     = cnt;
        req_err_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                lock_n = lock_hold;
                if (found) begin
                    gidx_n    = win;
                    grant_n   = ONE << win;
                    tx_req_n  = 1'b1;
                    tx_data_n = req_data[{win, 3'b000} +: 8];
                    state_n   = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_n     = '0;
`endif
                end
            end
            SEND: begin
                if (tx_ack) begin
                    tx_req_n  = 1'b0;
                    req_ack_n = grant;
                    ptr_n     = gidx;
                    owner_n   = gidx;
                    lock_n    = req_lock[gidx];
                    state_n   = DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt == LIMIT) begin
                    tx_req_n  = 1'b0;
                    req_ack_n = grant;
                    req_err_n = 1'b1;
                    ptr_n     = gidx;
                    lock_n    = 1'b0;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
`endif
            end
            DONE: begin
                grant_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= PTR_RST;
            gidx    <= '0;
            owner   <= '0;
            lock    <= 1'b0;
            grant   <= '0;
            tx_req  <= 1'b0;
            tx_data <= 8'h00;
            req_ack <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gidx    <= gidx_n;
            owner   <= owner_n;
            lock    <= lock_n;
            grant   <= grant_n;
            tx_req  <= tx_req_n;
            tx_data <= tx_data_n;
            req_ack <= req_ack_n;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Send-wait counter and timeout error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            req_err <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            req_err <= req_err_n;
        end
    end
`else
    assign req_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round robin,
// lock, reset mid-send, stray ack, and timeout when UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 65535;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ack;
    logic           req_err;
    logic [N-1:0]   grant;
    logic           tx_req;
    logic [7:0]     tx_data;
    logic           tx_ack;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_lock(req_lock), .req_ack(req_ack), .req_err(req_err),
        .grant(grant), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_lock = '0; tx_ack = 1'b0;
        req_data = {8'h40, 8'h30, 8'h20, 8'h10};
        step(); step();
        rst = 1'b0;
    endtask

    task automatic expect_send(input string tag, input logic [3:0] g,
                               input logic [7:0] d);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_txreq"}, tx_req, 1);
        chk({tag, "_txdata"}, tx_data, d);
    endtask

    task automatic ack_now(input string tag, input logic [3:0] g);
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        chk({tag, "_ack"}, req_ack, g);
        chk({tag, "_txdrop"}, tx_req, 0);
        chk({tag, "_err"}, req_err, 0);
    endtask

    task automatic done_idle(input string tag, input logic [3:0] nreq);
        req = nreq;
        step();
        chk({tag, "_ackend"}, req_ack, 0);
        chk({tag, "_gclr"}, grant, 0);
        chk({tag, "_errend"}, req_err, 0);
        step();
    endtask

    initial begin
        // 1: reset with all requesting, requester 0 first
        rst = 1'b1; req = 4'hF; req_lock = '0; tx_ack = 1'b0;
        req_data = {8'h40, 8'h30, 8'h20, 8'h10};
        step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_txreq", tx_req, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_err", req_err, 0);
        chk("rst_data", tx_data, 8'h00);
        rst = 1'b0;
        step();
        expect_send("rst_first", 4'b0001, 8'h10);
        ack_now("rst_first", 4'b0001);
        done_idle("rst_first", 4'b0000);
        chk("rst_idle_txreq", tx_req, 0);

        // 2: single requester, UART acks after 10 cycles
        do_reset();
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        step();
        expect_send("single", 4'b0100, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("single_hold", {tx_req, tx_data}, {1'b1, 8'hA5});
        end
        ack_now("single", 4'b0100);
        done_idle("single", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            chk("single_nosecond", tx_req, 0);
            step();
        end

        // 3: round robin 0,1,2,3 then 0 then 3
        do_reset();
        req = 4'hF;
        step();
        expect_send("rr0", 4'b0001, 8'h10);
        ack_now("rr0", 4'b0001);
        done_idle("rr0", 4'b1110);
        expect_send("rr1", 4'b0010, 8'h20);
        ack_now("rr1", 4'b0010);
        done_idle("rr1", 4'b1100);
        expect_send("rr2", 4'b0100, 8'h30);
        ack_now("rr2", 4'b0100);
        done_idle("rr2", 4'b1000);
        expect_send("rr3", 4'b1000, 8'h40);
        ack_now("rr3", 4'b1000);
        done_idle("rr3", 4'b0001);
        expect_send("rr0b", 4'b0001, 8'h10);
        ack_now("rr0b", 4'b0001);
        done_idle("rr0b", 4'b1001);
        expect_send("rr_wrap3", 4'b1000, 8'h40);
        ack_now("rr_wrap3", 4'b1000);
        done_idle("rr_wrap3", 4'b0000);

        // 4: locked 3-byte message from requester 1
        do_reset();
        req = 4'b0001;
        step();
        expect_send("lk_pre", 4'b0001, 8'h10);
        ack_now("lk_pre", 4'b0001);
        req_data[15:8] = 8'h11;
        req_lock = 4'b0010;
        done_idle("lk_pre", 4'b1011);
        expect_send("lk_b1", 4'b0010, 8'h11);
        ack_now("lk_b1", 4'b0010);
        req_data[15:8] = 8'h22;
        done_idle("lk_b1", 4'b1011);
        expect_send("lk_b2", 4'b0010, 8'h22);
        ack_now("lk_b2", 4'b0010);
        req_data[15:8] = 8'h33;
        req_lock = 4'b0000;
        done_idle("lk_b2", 4'b1011);
        expect_send("lk_b3", 4'b0010, 8'h33);
        ack_now("lk_b3", 4'b0010);
        done_idle("lk_b3", 4'b1001);
        expect_send("lk_then3", 4'b1000, 8'h40);
        ack_now("lk_then3", 4'b1000);
        done_idle("lk_then3", 4'b0001);
        expect_send("lk_then0", 4'b0001, 8'h10);
        ack_now("lk_then0", 4'b0001);
        done_idle("lk_then0", 4'b0000);

        // 5: reset mid-SEND, then stray tx_ack in IDLE
        do_reset();
        req = 4'b0001;
        step();
        expect_send("midrst", 4'b0001, 8'h10);
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0;
        chk("midrst_txreq", tx_req, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_ack", req_ack, 0);
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        chk("stray_ack", req_ack, 0);
        chk("stray_txreq", tx_req, 0);
        step();
        chk("stray_ack2", req_ack, 0);
        req = 4'b0100;
        step();
        expect_send("after_stray", 4'b0100, 8'h30);
        ack_now("after_stray", 4'b0100);
        done_idle("after_stray", 4'b0000);

`ifdef UART_ARB_TIMEOUT_EN
        // 6: timeout after 20 SEND cycles; ack on the 20th wins
        do_reset();
        req = 4'b0011;
        step();
        expect_send("to", 4'b0001, 8'h10);
        for (int i = 0; i < 19; i++) begin
            step();
            chk("to_wait", {tx_req, req_ack}, {1'b1, 4'b0000});
        end
        step();
        chk("to_ack", req_ack, 4'b0001);
        chk("to_err", req_err, 1);
        chk("to_txreq", tx_req, 0);
        done_idle("to", 4'b0010);
        expect_send("to_next", 4'b0010, 8'h20);
        for (int i = 0; i < 19; i++) step();
        ack_now("to_edge", 4'b0010);
        done_idle("to_edge", 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
